// File: rtl/peribus_irq_controller.sv
// peribus_irq_controller: latches, masks and prioritises peripheral irqs into one CPU request with vector, ack and EOI
module peribus_irq_controller #(
    parameter int NUM_SRC = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         addr,
    input  logic [15:0]        write_data,
    input  logic               write_en,
    input  logic               read_en,
    input  logic               chipselect,
    output logic [15:0]        read_data,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               cpu_irq,
    output logic [3:0]         cpu_vector,
    input  logic               cpu_ack
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2;
    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    logic [15:0] pending_q, pending_d, enable_q, enable_d, mode_q, mode_d, prev_q;
    logic [15:0] read_data_q, read_data_d;
    logic [1:0]  state_q, state_d;
    logic        cpu_irq_q, cpu_irq_d;
    logic [3:0]  cpu_vector_q, cpu_vector_d, winner;
    logic [15:0] src, req, set_term, clr_term;
    logic        wr, rd, ack, eoi;

    // Sources are widened to 16 bits so unused upper bits are constant zero everywhere
    always_comb begin
        src = 16'(irq_src);
        wr = chipselect && write_en;
        rd = chipselect && read_en;
        req = pending_q & enable_q;
        winner = 4'd0;
        for (int i = 15; i >= 0; i--) if (req[i]) winner = 4'(i);
        ack = state_q == REQ && cpu_ack;
        eoi = state_q == SERVICE && wr && addr == 2'd3;
        set_term = (mode_q & src & ~prev_q) | (~mode_q & src);
        clr_term = (wr && addr == 2'd0 ? write_data : 16'h0) | (ack ? 16'h1 << cpu_vector_q : 16'h0);
        pending_d = (set_term | (pending_q & ~clr_term)) & SRC_MASK;
        enable_d = wr && addr == 2'd1 ? write_data & SRC_MASK : enable_q;
        mode_d = wr && addr == 2'd2 ? write_data & SRC_MASK : mode_q;
        read_data_d = !rd ? read_data_q :
                      addr == 2'd0 ? pending_q :
                      addr == 2'd1 ? enable_q :
                      addr == 2'd2 ? mode_q : {11'h0, state_q == SERVICE, cpu_vector_q};
        state_d = state_q;
        cpu_irq_d = cpu_irq_q;
        cpu_vector_d = cpu_vector_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = REQ;
                cpu_irq_d = 1'b1;
                cpu_vector_d = winner;
            end
            REQ: if (ack) begin
                state_d = SERVICE;
                cpu_irq_d = 1'b0;
            end else if (!(|req)) begin
                state_d = IDLE;
                cpu_irq_d = 1'b0;
            end else cpu_vector_d = winner;
            SERVICE: state_d = eoi ? IDLE : SERVICE;
            default: begin
                state_d = IDLE;
                cpu_irq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending_q <= 16'h0;
            enable_q <= 16'h0;
            mode_q <= 16'h0;
            prev_q <= src;
            read_data_q <= 16'h0;
            state_q <= IDLE;
            cpu_irq_q <= 1'b0;
            cpu_vector_q <= 4'd0;
        end else begin
            pending_q <= pending_d;
            enable_q <= enable_d;
            mode_q <= mode_d;
            prev_q <= src;
            read_data_q <= read_data_d;
            state_q <= state_d;
            cpu_irq_q <= cpu_irq_d;
            cpu_vector_q <= cpu_vector_d;
        end
    end

    assign read_data = read_data_q;
    assign cpu_irq = cpu_irq_q;
    assign cpu_vector = cpu_vector_q;
endmodule
